// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the iterative divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic                 start;
  logic [2*WIDTH-1:0]   opx;
  logic [WIDTH-1:0]     opy;
  logic [2*WIDTH-1:0]   quo;
  logic [WIDTH-1:0]     rem;
  logic                 busy;
  logic                 done;
  logic                 dbz;

  // Requester side: issues operands and start, observes results.
  modport master (
    output start, opx, opy,
    input  quo, rem, busy, done, dbz
  );

  // Divider side.
  modport slave (
    input  start, opx, opy,
    output quo, rem, busy, done, dbz
  );

endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: 2*WIDTH-bit dividend over WIDTH-bit divisor,
// one quotient bit per clock. A zero divisor finishes in one cycle with dbz set.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(DW + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       dvd_q, dvd_d;     // dividend, shifted out MSB first
  logic [DW-1:0]       quot_q, quot_d;   // working quotient
  logic [WIDTH:0]      prem_q, prem_d;   // partial remainder, one spare bit
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]       quo_q, quo_d;     // visible results, held during BUSY
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic [WIDTH:0]      prem_shift;
  logic [WIDTH:0]      prem_next;
  logic [DW-1:0]       quot_next;
  logic                take;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    prem_shift = {prem_q[WIDTH-1:0], dvd_q[DW-1]};
    take       = (prem_shift >= {1'b0, dvs_q});
    prem_next  = take ? (prem_shift - {1'b0, dvs_q}) : prem_shift;
    quot_next  = {quot_q[DW-2:0], take};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d  = bus.opx;
          dvs_d  = bus.opy;
          prem_d = '0;
          quot_d = '0;
          cnt_d  = CntW'(DW);
          dbz_d  = 1'b0;
          if (bus.opy == '0) begin
            // Divide by zero resolves immediately without entering BUSY.
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quo_d  = '1;
            rem_d  = bus.opx[WIDTH-1:0];
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        dvd_d  = dvd_q << 1;
        prem_d = prem_next;
        quot_d = quot_next;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          quo_d   = quot_next;
          rem_d   = prem_next[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      quot_q  <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, basic divides, divide-by-zero,
// ignored start, reset abort and back-to-back exact-multiple divides.
module tb_seq_divider;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Pulse start for one edge and wait (bounded) for done; lat = edges after the start edge.
  task automatic do_op(input logic [31:0] x, input logic [15:0] y, output int lat);
    bus.opx   = x;
    bus.opy   = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opx   = '0;
    bus.opy   = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (bus.quo !== 32'h0) begin n_fail++; $display("FAIL reset_quo got %h want 0", bus.quo); end
    n_checks++; if (bus.rem !== 16'h0) begin n_fail++; $display("FAIL reset_rem got %h want 0", bus.rem); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.dbz); end
  endtask

  task automatic test_basic();
    int nbusy;
    int early_done;
    bus.opx   = 32'd100;
    bus.opy   = 16'd7;
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    nbusy      = 0;
    early_done = 0;
    while (bus.busy === 1'b1 && nbusy < 100) begin
      if (bus.done) early_done++;
      nbusy++;
      tick();
    end
    n_checks++; if (nbusy !== 32) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 32", nbusy); end
    n_checks++; if (early_done !== 0) begin n_fail++; $display("FAIL basic_done_while_busy got %0d want 0", early_done); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", bus.done); end
    n_checks++; if (bus.quo !== 32'd14) begin n_fail++; $display("FAIL basic_quo got %0d want 14", bus.quo); end
    n_checks++; if (bus.rem !== 16'd2) begin n_fail++; $display("FAIL basic_rem got %0d want 2", bus.rem); end
    n_checks++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", bus.dbz); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    n_checks++; if (bus.quo !== 32'd14) begin n_fail++; $display("FAIL basic_quo_hold got %0d want 14", bus.quo); end
  endtask

  task automatic test_values();
    int lat;
    do_op(32'hFFFE0001, 16'hFFFF, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL max_latency got %0d want 32", lat); end
    n_checks++; if (bus.quo !== 32'h0000FFFF) begin n_fail++; $display("FAIL max_quo got %h want 0000ffff", bus.quo); end
    n_checks++; if (bus.rem !== 16'h0) begin n_fail++; $display("FAIL max_rem got %h want 0", bus.rem); end
    tick();
    do_op(32'd5, 16'd9, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL small_latency got %0d want 32", lat); end
    n_checks++; if (bus.quo !== 32'd0) begin n_fail++; $display("FAIL small_quo got %0d want 0", bus.quo); end
    n_checks++; if (bus.rem !== 16'd5) begin n_fail++; $display("FAIL small_rem got %0d want 5", bus.rem); end
    tick();
  endtask

  task automatic test_dbz();
    int lat;
    do_op(32'h12345678, 16'h0, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dbz_latency got %0d want 0", lat); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.quo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_quo got %h want ffffffff", bus.quo); end
    n_checks++; if (bus.rem !== 16'h5678) begin n_fail++; $display("FAIL dbz_rem got %h want 5678", bus.rem); end
    n_checks++; if (bus.dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", bus.dbz); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dbz_done_pulse got %b want 0", bus.done); end
    n_checks++; if (bus.dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got %b want 1", bus.dbz); end
    do_op(32'd100, 16'd7, lat);
    n_checks++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL dbz_clear got %b want 0", bus.dbz); end
    n_checks++; if (bus.quo !== 32'd14) begin n_fail++; $display("FAIL dbz_next_quo got %0d want 14", bus.quo); end
    tick();
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [31:0] q;
    logic [15:0] r;
    ndone = 0;
    q = '0;
    r = '0;
    bus.opx   = 32'd100;
    bus.opy   = 16'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.opx   = 32'd50;
    bus.opy   = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done) begin
        ndone++;
        q = bus.quo;
        r = bus.rem;
      end
      tick();
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL ignore_quo got %0d want 14", q); end
    n_checks++; if (r !== 16'd2) begin n_fail++; $display("FAIL ignore_rem got %0d want 2", r); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int lat;
    ndone = 0;
    bus.opx   = 32'd100;
    bus.opy   = 16'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.quo !== 32'h0) begin n_fail++; $display("FAIL abort_quo got %h want 0", bus.quo); end
    n_checks++; if (bus.rem !== 16'h0) begin n_fail++; $display("FAIL abort_rem got %h want 0", bus.rem); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_done_count got %0d want 0", ndone); end
    do_op(32'h00000C80, 16'h0010, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL restart_latency got %0d want 32", lat); end
    n_checks++; if (bus.quo !== 32'h000000C8) begin n_fail++; $display("FAIL restart_quo got %h want 000000c8", bus.quo); end
    n_checks++; if (bus.rem !== 16'h0) begin n_fail++; $display("FAIL restart_rem got %h want 0", bus.rem); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] av[200];
    logic [15:0] bv[200];
    int prev;
    int w;
    for (int i = 0; i < 200; i++) begin
      av[i] = 16'({$random} % 17'h10000);
      bv[i] = 16'({$random} % 17'h10000);
      if (bv[i] == 16'h0) bv[i] = 16'h1;
    end
    prev      = -1;
    bus.opx   = 32'(av[0]) * 32'(bv[0]);
    bus.opy   = bv[0];
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!bus.done && w < 100);
      if (!bus.done) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_timeout op %0d got no done want done within 100 cycles", i);
        break;
      end
      n_checks++; if (bus.quo !== {16'h0, av[i]}) begin n_fail++; $display("FAIL b2b_quo op %0d got %h want %h", i, bus.quo, {16'h0, av[i]}); end
      n_checks++; if (bus.rem !== 16'h0) begin n_fail++; $display("FAIL b2b_rem op %0d got %h want 0", i, bus.rem); end
      if (prev >= 0) begin
        n_checks++; if (cycle - prev !== 33) begin n_fail++; $display("FAIL b2b_spacing op %0d got %0d want 33", i, cycle - prev); end
      end
      prev = cycle;
      if (i < 199) begin
        bus.opx = 32'(av[i+1]) * 32'(bv[i+1]);
        bus.opy = bv[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_dbz();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
